// File: rtl/t09_mode_button_pulser.sv
// Mode-button front end: synchronise, debounce and edge-detect a raw push button and
// emit one-cycle 'signal' pulses per press, with optional auto-repeat while held.
module t09_mode_button_pulser #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 32,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic button_i,
    input  logic en,
    output logic signal,
    output logic pressed,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             REP_ON    = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESSED,
        ST_REPEATING
    } state_t;

    logic             sync1_reg;
    logic             sync_q_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_reg;
    state_t           state_reg;

    logic db_accept;
    logic db_rise;
    logic db_fall;

    // The FSM reacts on the same edge the debounced level changes, so it uses the
    // acceptance condition rather than a delayed copy of 'pressed'.
    assign db_accept = (sync_q_reg != pressed) && (db_cnt_reg == DB_LAST);
    assign db_rise   = db_accept && sync_q_reg;
    assign db_fall   = db_accept && !sync_q_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_reg  <= 1'b0;
            sync_q_reg <= 1'b0;
        end else begin
            sync1_reg  <= button_i;
            sync_q_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            db_cnt_reg <= '0;
            pressed    <= 1'b0;
        end else if (sync_q_reg == pressed) begin
            db_cnt_reg <= '0;
        end else if (db_accept) begin
            pressed    <= sync_q_reg;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= ST_RELEASED;
            hold_cnt_reg <= '0;
            rep_cnt_reg  <= '0;
            signal       <= 1'b0;
            held         <= 1'b0;
        end else begin
            signal <= 1'b0;
            // Disable and release both take priority over any hold/repeat event.
            if (!en || db_fall) begin
                state_reg    <= ST_RELEASED;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
                held         <= 1'b0;
            end else begin
                case (state_reg)
                    ST_RELEASED: begin
                        if (db_rise) begin
                            state_reg    <= ST_PRESSED;
                            signal       <= 1'b1;
                            hold_cnt_reg <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg    <= ST_REPEATING;
                            held         <= 1'b1;
                            signal       <= REP_ON;
                            hold_cnt_reg <= '0;
                            rep_cnt_reg  <= '0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                    ST_REPEATING: begin
                        if (rep_cnt_reg == REP_LAST) begin
                            signal      <= REP_ON;
                            rep_cnt_reg <= '0;
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_RELEASED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t09_mode_button_pulser.sv
// Randomised scoreboard bench: a press-timing model predicts pulse edges and debounced
// levels for a repeating and a non-repeating instance driven by the same button.
module tb_t09_mode_button_pulser;

    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic button = 1'b0;
    logic en = 1'b1;
    logic sig_a, prs_a, hld_a;
    logic sig_b, prs_b, hld_b;

    always #5 clk = ~clk;

    t09_mode_button_pulser #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .nrst(nrst), .button_i(button), .en(en),
        .signal(sig_a), .pressed(prs_a), .held(hld_a)
    );

    t09_mode_button_pulser #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .nrst(nrst), .button_i(button), .en(en),
        .signal(sig_b), .pressed(prs_b), .held(hld_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int ecount = 0;

    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int e;
        bit p;
        bit h;
    } lvl_t;

    lvl_t lvl_q[$];
    int   pq_a[$];
    int   pq_b[$];

    // Reference model: button history, debounced level, and elapsed time since the press.
    bit m_hist0, m_hist1;
    bit m_deb;
    int m_run;
    bit m_active;
    int m_t;

    function automatic void model_step(input int e, input bit b, input bit e_n, input bit rstn);
        bit sq, rise, fall, held_exp;
        lvl_t l;
        rise = 1'b0;
        fall = 1'b0;
        if (!rstn) begin
            m_hist0 = 0; m_hist1 = 0; m_deb = 0; m_run = 0; m_active = 0; m_t = 0;
            l.e = e; l.p = 0; l.h = 0;
            lvl_q.push_back(l);
            return;
        end
        sq = m_hist0;
        m_hist0 = m_hist1;
        m_hist1 = b;
        m_run = (sq != m_deb) ? m_run + 1 : 0;
        if (m_run == D) begin
            m_deb = sq;
            m_run = 0;
            rise = sq;
            fall = !sq;
        end
        if (rise && e_n) begin
            m_active = 1;
            m_t = 0;
            pq_a.push_back(e);
            pq_b.push_back(e);
        end else if (fall || !e_n) begin
            m_active = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t >= H && (m_t - H) % R == 0) pq_a.push_back(e);
        end
        held_exp = m_active && (m_t >= H);
        l.e = e; l.p = m_deb; l.h = held_exp;
        lvl_q.push_back(l);
    endfunction

    // Monitor: pops expected pulses when a DUT presents one, and flags expected pulses that never came.
    always @(negedge clk) begin
        while (pq_a.size() > 0 && pq_a[0] < ecount) begin
            vectors++; miscompares++;
            $display("FAIL pulse_a missed: got none, expected signal at edge %0d", pq_a.pop_front());
        end
        while (pq_b.size() > 0 && pq_b[0] < ecount) begin
            vectors++; miscompares++;
            $display("FAIL pulse_b missed: got none, expected signal at edge %0d", pq_b.pop_front());
        end
        if (sig_a === 1'b1) begin
            vectors++;
            if (pq_a.size() > 0 && pq_a[0] == ecount) void'(pq_a.pop_front());
            else begin
                miscompares++;
                $display("FAIL pulse_a unexpected: got signal=1 at edge %0d, expected 0", ecount);
            end
        end
        if (sig_b === 1'b1) begin
            vectors++;
            if (pq_b.size() > 0 && pq_b[0] == ecount) void'(pq_b.pop_front());
            else begin
                miscompares++;
                $display("FAIL pulse_b unexpected: got signal=1 at edge %0d, expected 0", ecount);
            end
        end
        if (lvl_q.size() > 0 && lvl_q[0].e == ecount) begin
            lvl_t l;
            l = lvl_q.pop_front();
            vectors++;
            if (prs_a !== l.p || hld_a !== l.h || prs_b !== l.p || hld_b !== l.h) begin
                miscompares++;
                $display("FAIL levels edge %0d: got pressed=%b/%b held=%b/%b, expected pressed=%b held=%b",
                         ecount, prs_a, prs_b, hld_a, hld_b, l.p, l.h);
            end
        end
    end

    task automatic drive(input bit b, input bit e_n, input bit r);
        @(negedge clk);
        #1;
        button = b;
        en = e_n;
        if (nrst && !r) begin
            nrst = 1'b0;
            #1;
            vectors++;
            if ({sig_a, prs_a, hld_a, sig_b, prs_b, hld_b} !== 6'b0) begin
                miscompares++;
                $display("FAIL async_reset: got sig/prs/hld a=%b%b%b b=%b%b%b, expected all 0",
                         sig_a, prs_a, hld_a, sig_b, prs_b, hld_b);
            end
        end
        nrst = r;
        model_step(ecount + 1, b, e_n, r);
    endtask

    task automatic hold_level(input bit b, input int n);
        for (int i = 0; i < n; i++) drive(b, 1'b1, 1'b1);
    endtask

    initial begin
        bit pat[6];
        bit en_burst;
        int len;
        pat = '{1, 0, 1, 1, 0, 1};

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        hold_level(1'b0, 5);
        // Clean short press.
        hold_level(1'b1, 6);
        hold_level(1'b0, 10);
        // Bounce never reaching the debounce threshold.
        for (int i = 0; i < 6; i++) drive(pat[i], 1'b1, 1'b1);
        hold_level(1'b0, 10);
        // Long hold with auto-repeat, then release.
        hold_level(1'b1, 40);
        hold_level(1'b0, 12);
        // Disable during a press, re-enable while still held, then a fresh press.
        hold_level(1'b1, 8);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
        hold_level(1'b1, 8);
        hold_level(1'b0, 10);
        hold_level(1'b1, 8);
        hold_level(1'b0, 10);
        // Reset while repeating with the button still down.
        hold_level(1'b1, 20);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0);
        hold_level(1'b1, 24);
        hold_level(1'b0, 10);
        // Random bursts: bounces, holds, occasional disable and reset.
        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
            en_burst = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < len; i++) drive(1'b1, en_burst, 1'b1);
            if ($urandom_range(0, 9) == 0) drive(1'b1, 1'b1, 1'b0);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) drive(1'b0, 1'b1, 1'b1);
        end
        hold_level(1'b0, 12);
        @(negedge clk);
        #2;
        vectors++;
        if (pq_a.size() != 0 || pq_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pulses still pending, expected 0/0", pq_a.size(), pq_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
